// File: rtl/decode_pkg.sv
// Shared decode definitions: opcode-length field, halfword width and the
// compressed-instruction predicate used by the aligner and the RVC decoder.
package decode_pkg;

    localparam logic [1:0] C_OPC32 = 2'b11;
    localparam int         HW_W    = 16;

    // FETCH_HI: the next accepted word contributes only its upper halfword.
    typedef enum logic {
        FETCH_FULL,
        FETCH_HI
    } fetch_state_e;

    function automatic logic is_com(input logic [HW_W-1:0] hw);
        return hw[1:0] != C_OPC32;
    endfunction

endpackage

// File: rtl/decode_align_q_hw_ring.sv
// Halfword ring buffer: pushes and pops one or two entries per cycle and
// exposes the two oldest entries plus the occupancy count.
module hw_ring
    import decode_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clr_i,
    input  logic [1:0]              push_n_i,
    input  logic [HW_W-1:0]         push_hw0_i,
    input  logic [HW_W-1:0]         push_hw1_i,
    input  logic [1:0]              pop_n_i,
    output logic [HW_W-1:0]         peek0_o,
    output logic [HW_W-1:0]         peek1_o,
    output logic [$clog2(DEPTH):0]  count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [HW_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;

    // NOTE: storage has no reset; count gates every consumer, so stale entries are never observed.
    always_ff @(posedge clk_i) begin
        if (push_n_i != 2'd0) mem_q[wr_ptr_q] <= push_hw0_i;
        if (push_n_i == 2'd2) mem_q[wr_ptr_q + PW'(1)] <= push_hw1_i;
    end

    // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clr_i) begin
            rd_ptr_q <= wr_ptr_q;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + PW'(push_n_i);
            rd_ptr_q <= rd_ptr_q + PW'(pop_n_i);
            count_q  <= count_q + CW'(push_n_i) - CW'(pop_n_i);
        end
    end

    assign peek0_o = mem_q[rd_ptr_q];
    assign peek1_o = mem_q[rd_ptr_q + PW'(1)];
    assign count_o = count_q;

endmodule

// File: rtl/decode_align_q.sv
// Instruction alignment queue: splits fetch words into halfwords and presents
// one RV32C/RV32 instruction per cycle with its PC; supports redirect.
module decode_align_q
    import decode_pkg::*;
#(
    parameter int              DEPTH_HW = 8,
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            fetch_vld_i,
    output logic            fetch_rdy_o,
    input  logic [31:0]     fetch_data_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] flush_pc_i,
    output logic            inst_vld_o,
    input  logic            inst_rdy_i,
    output logic [31:0]     inst_o,
    output logic [XLEN-1:0] inst_pc_o,
    output logic            inst_com_o
);

    localparam int CW = $clog2(DEPTH_HW) + 1;

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [CW-1:0]   count;
    logic [HW_W-1:0] h0, h1, push_hw0;
    logic [1:0]      push_n, pop_n;
    logic            drop_lo, accept, fire, h0_com;

    hw_ring #(
        .DEPTH (DEPTH_HW)
    ) u_ring (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clr_i      (flush_i),
        .push_n_i   (push_n),
        .push_hw0_i (push_hw0),
        .push_hw1_i (fetch_data_i[31:16]),
        .pop_n_i    (pop_n),
        .peek0_o    (h0),
        .peek1_o    (h1),
        .count_o    (count)
    );

    // Two free slots guarantee a full word always fits, so no overflow check is needed.
    assign drop_lo     = (state_q == FETCH_HI);
    assign fetch_rdy_o = (count <= CW'(DEPTH_HW - 2));
    assign accept      = fetch_vld_i & fetch_rdy_o & ~flush_i;
    assign push_n      = accept ? (drop_lo ? 2'd1 : 2'd2) : 2'd0;
    assign push_hw0    = drop_lo ? fetch_data_i[31:16] : fetch_data_i[15:0];

    assign h0_com      = is_com(h0);
    assign inst_vld_o  = ((count >= CW'(1)) & h0_com) | (count >= CW'(2));
    assign inst_com_o  = inst_vld_o & h0_com;
    assign inst_o      = !inst_vld_o ? 32'h0 :
                         h0_com      ? {{HW_W{1'b0}}, h0} : {h1, h0};
    assign inst_pc_o   = pc_q;

    assign fire  = inst_vld_o & inst_rdy_i & ~flush_i;
    assign pop_n = fire ? (h0_com ? 2'd1 : 2'd2) : 2'd0;

    // NOTE: defaults come first so every path assigns state_d and pc_d and no latch is inferred.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (flush_i) begin
            state_d = flush_pc_i[1] ? FETCH_HI : FETCH_FULL;
            pc_d    = flush_pc_i;
        end else begin
            if (accept) state_d = FETCH_FULL;
            if (fire)   pc_d    = pc_q + (h0_com ? XLEN'(2) : XLEN'(4));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RESET_PC[1] ? FETCH_HI : FETCH_FULL;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

endmodule

// File: tb/tb_decode_align_q.sv
// Bench for decode_align_q: directed scenarios plus randomized traffic checked
// against a halfword-queue reference model.
module tb_decode_align_q;

    localparam int          DEPTH_HW = 8;
    localparam int          XLEN     = 32;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        fetch_vld_i;
    logic        fetch_rdy_o;
    logic [31:0] fetch_data_i;
    logic        flush_i;
    logic [31:0] flush_pc_i;
    logic        inst_vld_o;
    logic        inst_rdy_i;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_com_o;

    int errors = 0;
    int checks = 0;

    // Reference model: pending halfwords, next PC, and the drop-low-halfword flag.
    logic [15:0] mq[$];
    logic [31:0] m_pc;
    logic        m_drop;
    logic        exp_vld, exp_com, exp_frdy;
    logic [31:0] exp_inst, exp_pc;

    always #5 clk_i = ~clk_i;

    decode_align_q #(
        .DEPTH_HW (DEPTH_HW),
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .fetch_vld_i  (fetch_vld_i),
        .fetch_rdy_o  (fetch_rdy_o),
        .fetch_data_i (fetch_data_i),
        .flush_i      (flush_i),
        .flush_pc_i   (flush_pc_i),
        .inst_vld_o   (inst_vld_o),
        .inst_rdy_i   (inst_rdy_i),
        .inst_o       (inst_o),
        .inst_pc_o    (inst_pc_o),
        .inst_com_o   (inst_com_o)
    );

    function automatic logic [65:0] obs();
        return {inst_vld_o, inst_com_o, inst_pc_o, inst_o};
    endfunction

    function automatic logic [65:0] pack(input logic v, input logic c,
                                         input logic [31:0] pc, input logic [31:0] ins);
        return {v, c, pc, ins};
    endfunction

    function automatic void model_eval();
        exp_vld  = 1'b0;
        exp_com  = 1'b0;
        exp_inst = 32'h0;
        exp_pc   = m_pc;
        exp_frdy = (mq.size() <= DEPTH_HW - 2);
        if (mq.size() >= 1) begin
            if (mq[0][1:0] != 2'b11) begin
                exp_vld  = 1'b1;
                exp_com  = 1'b1;
                exp_inst = {16'h0, mq[0]};
            end else if (mq.size() >= 2) begin
                exp_vld  = 1'b1;
                exp_inst = {mq[1], mq[0]};
            end
        end
    endfunction

    // Advance one clock, applying the current inputs to the model first.
    task automatic tick();
        model_eval();
        if (flush_i) begin
            mq.delete();
            m_pc   = flush_pc_i;
            m_drop = flush_pc_i[1];
        end else begin
            if (exp_vld && inst_rdy_i) begin
                void'(mq.pop_front());
                if (!exp_com) void'(mq.pop_front());
                m_pc = m_pc + (exp_com ? 32'd2 : 32'd4);
            end
            if (fetch_vld_i && exp_frdy) begin
                if (!m_drop) mq.push_back(fetch_data_i[15:0]);
                mq.push_back(fetch_data_i[31:16]);
                m_drop = 1'b0;
            end
        end
        @(posedge clk_i);
        #1;
        model_eval();
    endtask

    task automatic restart(input logic [31:0] pc);
        flush_i     = 1'b1;
        flush_pc_i  = pc;
        fetch_vld_i = 1'b0;
        inst_rdy_i  = 1'b0;
        tick();
        flush_i = 1'b0;
        checks++;
        if (inst_vld_o !== 1'b0 || inst_pc_o !== pc) begin
            errors++;
            $display("FAIL restart: vld=%b pc=%h, want vld=0 pc=%h", inst_vld_o, inst_pc_o, pc);
        end
    endtask

    task automatic test_reset();
        logic [65:0] want;
        rst_ni = 1'b0;
        #12;
        want = pack(1'b0, 1'b0, RESET_PC, 32'h0);
        checks++;
        if (obs() !== want || fetch_rdy_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: got %h rdy=%b, want %h rdy=1", obs(), fetch_rdy_o, want);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_aligned32();
        logic [65:0] want;
        fetch_vld_i  = 1'b1;
        fetch_data_i = 32'h00A00093;
        tick();
        fetch_vld_i = 1'b0;
        want = pack(1'b1, 1'b0, 32'h0, 32'h00A00093);
        checks++;
        if (obs() !== want) begin
            errors++;
            $display("FAIL aligned32: got %h, want %h", obs(), want);
        end
        inst_rdy_i = 1'b1;
        tick();
        inst_rdy_i = 1'b0;
        checks++;
        if (inst_vld_o !== 1'b0 || inst_pc_o !== 32'h4) begin
            errors++;
            $display("FAIL aligned32_consumed: vld=%b pc=%h, want vld=0 pc=4", inst_vld_o, inst_pc_o);
        end
    endtask

    task automatic test_two_com();
        logic [65:0] want;
        restart(32'h0);
        fetch_vld_i  = 1'b1;
        fetch_data_i = 32'h00010001;
        inst_rdy_i   = 1'b1;
        tick();
        fetch_vld_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            want = pack(1'b1, 1'b1, 32'(2 * k), 32'h1);
            checks++;
            if (obs() !== want) begin
                errors++;
                $display("FAIL two_com_%0d: got %h, want %h", k, obs(), want);
            end
            tick();
        end
        checks++;
        if (inst_vld_o !== 1'b0) begin
            errors++;
            $display("FAIL two_com_empty: vld=%b, want 0", inst_vld_o);
        end
        inst_rdy_i = 1'b0;
    endtask

    task automatic test_straddle();
        logic [65:0] want;
        restart(32'h0);
        fetch_vld_i  = 1'b1;
        fetch_data_i = 32'h00930001;
        inst_rdy_i   = 1'b1;
        tick();
        fetch_vld_i = 1'b0;
        want = pack(1'b1, 1'b1, 32'h0, 32'h1);
        checks++;
        if (obs() !== want) begin
            errors++;
            $display("FAIL straddle_first: got %h, want %h", obs(), want);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (inst_vld_o !== 1'b0) begin
                errors++;
                $display("FAIL straddle_wait_%0d: vld=%b, want 0", k, inst_vld_o);
            end
        end
        fetch_vld_i  = 1'b1;
        fetch_data_i = 32'h000100A0;
        tick();
        fetch_vld_i = 1'b0;
        want = pack(1'b1, 1'b0, 32'h2, 32'h00A00093);
        checks++;
        if (obs() !== want) begin
            errors++;
            $display("FAIL straddle_32: got %h, want %h", obs(), want);
        end
        tick();
        want = pack(1'b1, 1'b1, 32'h6, 32'h1);
        checks++;
        if (obs() !== want) begin
            errors++;
            $display("FAIL straddle_tail: got %h, want %h", obs(), want);
        end
        tick();
        inst_rdy_i = 1'b0;
    endtask

    task automatic test_flush();
        logic [65:0] want;
        restart(32'h2);
        fetch_vld_i  = 1'b1;
        fetch_data_i = 32'h00010001;
        tick();
        tick();
        flush_i      = 1'b1;
        flush_pc_i   = 32'h102;
        fetch_data_i = 32'h12345678;
        tick();
        flush_i     = 1'b0;
        fetch_vld_i = 1'b0;
        checks++;
        if (inst_vld_o !== 1'b0 || inst_pc_o !== 32'h102 || fetch_rdy_o !== 1'b1) begin
            errors++;
            $display("FAIL flush_discard: vld=%b pc=%h rdy=%b, want vld=0 pc=102 rdy=1",
                     inst_vld_o, inst_pc_o, fetch_rdy_o);
        end
        fetch_vld_i  = 1'b1;
        fetch_data_i = 32'h00010000;
        tick();
        fetch_vld_i = 1'b0;
        want = pack(1'b1, 1'b1, 32'h102, 32'h1);
        checks++;
        if (obs() !== want) begin
            errors++;
            $display("FAIL flush_target: got %h, want %h", obs(), want);
        end
        inst_rdy_i = 1'b1;
        tick();
        inst_rdy_i = 1'b0;
        checks++;
        if (inst_vld_o !== 1'b0 || inst_pc_o !== 32'h104) begin
            errors++;
            $display("FAIL flush_drained: vld=%b pc=%h, want vld=0 pc=104", inst_vld_o, inst_pc_o);
        end
    endtask

    task automatic test_full();
        logic [65:0] want;
        restart(32'h0);
        fetch_vld_i  = 1'b1;
        fetch_data_i = 32'h00010001;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (fetch_rdy_o !== 1'b1) begin
                errors++;
                $display("FAIL full_fill_%0d: rdy=%b, want 1", i, fetch_rdy_o);
            end
            tick();
        end
        tick();
        fetch_vld_i = 1'b0;
        want = pack(1'b1, 1'b1, 32'h0, 32'h1);
        checks++;
        if (fetch_rdy_o !== 1'b0 || obs() !== want) begin
            errors++;
            $display("FAIL full_hold: rdy=%b got %h, want rdy=0 %h", fetch_rdy_o, obs(), want);
        end
        inst_rdy_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            want = pack(1'b1, 1'b1, 32'(2 * k), 32'h1);
            checks++;
            if (obs() !== want || fetch_rdy_o !== (8 - k <= 6)) begin
                errors++;
                $display("FAIL full_drain_%0d: got %h rdy=%b, want %h rdy=%b",
                         k, obs(), fetch_rdy_o, want, (8 - k <= 6));
            end
            tick();
        end
        inst_rdy_i = 1'b0;
        checks++;
        if (inst_vld_o !== 1'b0 || inst_pc_o !== 32'h10) begin
            errors++;
            $display("FAIL full_empty: vld=%b pc=%h, want vld=0 pc=10", inst_vld_o, inst_pc_o);
        end
    endtask

    task automatic test_async_reset();
        logic [65:0] want;
        restart(32'h0);
        fetch_vld_i  = 1'b1;
        fetch_data_i = 32'h00010001;
        repeat (3) tick();
        fetch_vld_i = 1'b0;
        inst_rdy_i  = 1'b1;
        tick();
        inst_rdy_i = 1'b0;
        #2;
        rst_ni = 1'b0;
        #1;
        want = pack(1'b0, 1'b0, RESET_PC, 32'h0);
        checks++;
        if (obs() !== want || fetch_rdy_o !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: got %h rdy=%b, want %h rdy=1", obs(), fetch_rdy_o, want);
        end
        mq.delete();
        m_pc   = RESET_PC;
        m_drop = RESET_PC[1];
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        fetch_vld_i  = 1'b1;
        fetch_data_i = 32'h00A00093;
        tick();
        fetch_vld_i = 1'b0;
        want = pack(1'b1, 1'b0, RESET_PC, 32'h00A00093);
        checks++;
        if (obs() !== want) begin
            errors++;
            $display("FAIL after_reset: got %h, want %h", obs(), want);
        end
        inst_rdy_i = 1'b1;
        tick();
        inst_rdy_i = 1'b0;
    endtask

    task automatic test_random();
        logic [65:0] want, got;
        for (int n = 0; n < 600; n++) begin
            fetch_vld_i  = ($urandom % 4) != 0;
            fetch_data_i = $urandom;
            inst_rdy_i   = ($urandom % 10) < 7;
            flush_i      = ($urandom % 40) == 0;
            flush_pc_i   = ($urandom % 2) ? ($urandom & 32'hFFFF_FFFE)
                                          : (32'hFFFF_FFF8 | ($urandom & 32'h6));
            tick();
            want = pack(exp_vld, exp_com, exp_pc, exp_inst);
            got  = obs();
            if (!exp_vld) got = {got[65], 1'b0, got[63:32], 32'h0};
            checks++;
            if (got !== want || fetch_rdy_o !== exp_frdy) begin
                errors++;
                $display("FAIL random_%0d: got %h rdy=%b, want %h rdy=%b",
                         n, obs(), fetch_rdy_o, want, exp_frdy);
            end
        end
        flush_i     = 1'b0;
        fetch_vld_i = 1'b0;
        inst_rdy_i  = 1'b0;
    endtask

    initial begin
        rst_ni       = 1'b0;
        fetch_vld_i  = 1'b0;
        fetch_data_i = 32'h0;
        flush_i      = 1'b0;
        flush_pc_i   = 32'h0;
        inst_rdy_i   = 1'b0;
        m_pc         = RESET_PC;
        m_drop       = RESET_PC[1];
        test_reset();
        test_aligned32();
        test_two_com();
        test_straddle();
        test_flush();
        test_full();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
